// File: rtl/ps2_key_pkg.sv
// Shared constants for the PS/2 key controller: set-2 scan codes, game key
// indices, prefix FSM states and the scan-code to game-key decoder.
package ps2_key_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_P     = 8'h4D;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_ESC   = 8'h76;

    localparam logic [1:0] KEY_SPACE = 2'd0;
    localparam logic [1:0] KEY_P     = 2'd1;
    localparam logic [1:0] KEY_R     = 2'd2;
    localparam logic [1:0] KEY_ESC   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

    // Returns {hit, key_index}; hit is 0 for any code that is not a game key.
    function automatic logic [2:0] decode_game_key(input logic [7:0] code);
        case (code)
            SC_SPACE: decode_game_key = {1'b1, KEY_SPACE};
            SC_P:     decode_game_key = {1'b1, KEY_P};
            SC_R:     decode_game_key = {1'b1, KEY_R};
            SC_ESC:   decode_game_key = {1'b1, KEY_ESC};
            default:  decode_game_key = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small synchronous FIFO for key events; wrap-bit pointers distinguish full
// from empty, and a push is accepted while full if a pop happens the same cycle.
module key_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head reads as zero when empty so the outputs have a defined reset value.
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ps2_key_controller.sv
// Turns raw PS/2 set-2 bytes into game key press/release events with held-key
// tracking, typematic suppression, a FLAP strobe and a buffered event stream.
module ps2_key_controller
    import ps2_key_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       CODE_VALID,
    input  logic [7:0] CODE,
    input  logic       CODE_ERR,
    output logic       EVT_VALID,
    input  logic       EVT_READY,
    output logic [1:0] EVT_KEY,
    output logic       EVT_MAKE,
    output logic [3:0] KEYS_HELD,
    output logic       FLAP,
    output logic       OVERFLOW,
    output ps2_state_t FSM_STATE
);

    localparam int CW = $clog2(PREFIX_TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = CW'(PREFIX_TIMEOUT - 1);

    ps2_state_t    state;
    logic [CW-1:0] tmo_cnt;
    logic [2:0]    key_dec;
    logic          key_hit;
    logic [1:0]    key_idx;
    logic          byte_ok;
    logic          do_make;
    logic          do_break;
    logic          evt_push;
    logic [2:0]    evt_data;
    logic [2:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;

    always_comb begin
        key_dec  = decode_game_key(CODE);
        key_hit  = key_dec[2];
        key_idx  = key_dec[1:0];
        byte_ok  = CODE_VALID && !CODE_ERR;
        // Make only from IDLE on an unheld key; break only from BRK on a held key.
        do_make  = byte_ok && key_hit && (state == ST_IDLE) && !KEYS_HELD[key_idx];
        do_break = byte_ok && key_hit && (state == ST_BRK) && KEYS_HELD[key_idx];
        evt_push = do_make || do_break;
        evt_data = {key_idx, do_make};
    end

    // Event stream: an entry transfers on every cycle where EVT_VALID && EVT_READY;
    // EVT_KEY/EVT_MAKE hold steady while EVT_VALID is high and EVT_READY is low.
    assign fifo_pop  = EVT_VALID && EVT_READY;
    assign EVT_VALID = !fifo_empty;
    assign EVT_KEY   = fifo_head[2:1];
    assign EVT_MAKE  = fifo_head[0];
    assign FSM_STATE = state;

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .clk       (CLOCK_50),
        .rst       (RESET),
        .push      (evt_push),
        .push_data (evt_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            KEYS_HELD <= 4'b0000;
            FLAP      <= 1'b0;
            OVERFLOW  <= 1'b0;
        end else begin
            FLAP <= do_make && (key_idx == KEY_SPACE);
            if (do_make)       KEYS_HELD[key_idx] <= 1'b1;
            else if (do_break) KEYS_HELD[key_idx] <= 1'b0;
            // Dropped events still update held state; only the record is lost.
            if (evt_push && fifo_full && !fifo_pop) OVERFLOW <= 1'b1;

            if (CODE_VALID) begin
                tmo_cnt <= '0;
                if (CODE_ERR) begin
                    state <= ST_IDLE;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (CODE == SC_EXT)      state <= ST_EXT;
                            else if (CODE == SC_BRK) state <= ST_BRK;
                        end
                        ST_EXT:  state <= (CODE == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
                        default: state <= ST_IDLE;
                    endcase
                end
            end else if (state != ST_IDLE) begin
                if (tmo_cnt == TMO_LAST) begin
                    state   <= ST_IDLE;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_controller.sv
// Bench for ps2_key_controller: drives byte sequences, predicts events into a
// queue and compares them as the controller hands them out.
module tb_ps2_key_controller;
    import ps2_key_pkg::*;

    localparam int PT    = 20;
    localparam int DEPTH = 4;

    logic       CLOCK_50;
    logic       RESET;
    logic       CODE_VALID;
    logic [7:0] CODE;
    logic       CODE_ERR;
    logic       EVT_VALID;
    logic       EVT_READY;
    logic [1:0] EVT_KEY;
    logic       EVT_MAKE;
    logic [3:0] KEYS_HELD;
    logic       FLAP;
    logic       OVERFLOW;
    ps2_state_t FSM_STATE;

    logic [2:0] exp_q[$];
    logic [3:0] mon_exp;
    int         errors    = 0;
    int         checks    = 0;
    int         flap_cnt  = 0;
    int         exp_flaps = 0;

    ps2_key_controller #(
        .PREFIX_TIMEOUT (PT),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .CODE_VALID (CODE_VALID),
        .CODE       (CODE),
        .CODE_ERR   (CODE_ERR),
        .EVT_VALID  (EVT_VALID),
        .EVT_READY  (EVT_READY),
        .EVT_KEY    (EVT_KEY),
        .EVT_MAKE   (EVT_MAKE),
        .KEYS_HELD  (KEYS_HELD),
        .FLAP       (FLAP),
        .OVERFLOW   (OVERFLOW),
        .FSM_STATE  (FSM_STATE)
    );

    // Clock and watchdog
    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Driver: one-cycle strobe; returns on the negedge after the sampling edge.
    task automatic send_byte(input logic [7:0] b, input logic err);
        @(negedge CLOCK_50);
        CODE_VALID = 1'b1;
        CODE       = b;
        CODE_ERR   = err;
        @(negedge CLOCK_50);
        CODE_VALID = 1'b0;
        CODE       = 8'h00;
        CODE_ERR   = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Scoreboard: compare each transferred event against the oldest prediction.
    always @(negedge CLOCK_50) begin
        #1;
        if (FLAP) flap_cnt++;
        if (EVT_VALID && EVT_READY) begin
            if (exp_q.size() > 0) mon_exp = {1'b1, exp_q.pop_front()};
            else                  mon_exp = 4'b0000;
            check("evt", 32'({1'b1, EVT_KEY, EVT_MAKE}), 32'(mon_exp));
        end
    end

    initial begin
        RESET      = 1'b1;
        CODE_VALID = 1'b0;
        CODE       = 8'h00;
        CODE_ERR   = 1'b0;
        EVT_READY  = 1'b1;
        idle_cycles(3);
        check("rst_valid", 32'(EVT_VALID), 32'(0));
        check("rst_key",   32'({EVT_KEY, EVT_MAKE}), 32'(0));
        check("rst_held",  32'(KEYS_HELD), 32'(0));
        check("rst_flap",  32'(FLAP), 32'(0));
        check("rst_ovf",   32'(OVERFLOW), 32'(0));
        check("rst_state", 32'(FSM_STATE), 32'(ST_IDLE));
        RESET = 1'b0;
        idle_cycles(2);

        // Press and release SPACE
        exp_q.push_back({KEY_SPACE, 1'b1}); exp_flaps++;
        send_byte(SC_SPACE, 1'b0);
        check("s1_flap_hi", 32'(FLAP), 32'(1));
        check("s1_held",    32'(KEYS_HELD), 32'(4'b0001));
        idle_cycles(1);
        check("s1_flap_lo", 32'(FLAP), 32'(0));
        send_byte(SC_BRK, 1'b0);
        check("s1_brk_state", 32'(FSM_STATE), 32'(ST_BRK));
        exp_q.push_back({KEY_SPACE, 1'b0});
        send_byte(SC_SPACE, 1'b0);
        check("s1_released", 32'(KEYS_HELD), 32'(4'b0000));
        check("s1_flap_brk", 32'(FLAP), 32'(0));
        idle_cycles(2);

        // Typematic repeat of SPACE produces a single press
        exp_q.push_back({KEY_SPACE, 1'b1}); exp_flaps++;
        for (int i = 0; i < 3; i++) send_byte(SC_SPACE, 1'b0);
        check("s2_held", 32'(KEYS_HELD), 32'(4'b0001));
        exp_q.push_back({KEY_SPACE, 1'b0});
        send_byte(SC_BRK, 1'b0);
        send_byte(SC_SPACE, 1'b0);
        check("s2_released", 32'(KEYS_HELD), 32'(4'b0000));

        // Prefix timeout: state holds through PT-1 idle cycles, then returns to IDLE
        send_byte(SC_BRK, 1'b0);
        idle_cycles(PT - 1);
        check("s3_before_tmo", 32'(FSM_STATE), 32'(ST_BRK));
        idle_cycles(1);
        check("s3_after_tmo", 32'(FSM_STATE), 32'(ST_IDLE));
        exp_q.push_back({KEY_SPACE, 1'b1}); exp_flaps++;
        send_byte(SC_SPACE, 1'b0);
        check("s3_make", 32'(KEYS_HELD), 32'(4'b0001));
        check("s3_flap", 32'(FLAP), 32'(1));
        exp_q.push_back({KEY_SPACE, 1'b0});
        send_byte(SC_BRK, 1'b0);
        send_byte(SC_SPACE, 1'b0);

        // Extended break and errored bytes yield nothing
        send_byte(SC_EXT, 1'b0);
        check("s4_ext", 32'(FSM_STATE), 32'(ST_EXT));
        send_byte(SC_BRK, 1'b0);
        check("s4_ext_brk", 32'(FSM_STATE), 32'(ST_EXT_BRK));
        send_byte(SC_P, 1'b0);
        check("s4_ext_held", 32'(KEYS_HELD), 32'(4'b0000));
        send_byte(SC_P, 1'b1);
        check("s4_err_held", 32'(KEYS_HELD), 32'(4'b0000));
        send_byte(SC_BRK, 1'b0);
        send_byte(SC_SPACE, 1'b1);
        check("s4_err_state", 32'(FSM_STATE), 32'(ST_IDLE));
        idle_cycles(2);
        check("s4_no_evt", 32'(EVT_VALID), 32'(0));

        // Overflow with consumer stalled
        EVT_READY = 1'b0;
        exp_q.push_back({KEY_SPACE, 1'b1}); exp_flaps++;
        exp_q.push_back({KEY_P, 1'b1});
        exp_q.push_back({KEY_R, 1'b1});
        exp_q.push_back({KEY_ESC, 1'b1});
        send_byte(SC_SPACE, 1'b0);
        send_byte(SC_P, 1'b0);
        send_byte(SC_R, 1'b0);
        send_byte(SC_ESC, 1'b0);
        check("s5_no_ovf", 32'(OVERFLOW), 32'(0));
        send_byte(SC_BRK, 1'b0);
        send_byte(SC_SPACE, 1'b0);
        check("s5_ovf",  32'(OVERFLOW), 32'(1));
        check("s5_held", 32'(KEYS_HELD), 32'(4'b1110));
        check("s5_head", 32'({EVT_VALID, EVT_KEY, EVT_MAKE}), 32'({1'b1, KEY_SPACE, 1'b1}));
        EVT_READY = 1'b1;
        idle_cycles(DEPTH + 2);
        check("s5_drained", 32'(EVT_VALID), 32'(0));

        // Reset in the middle of a break sequence
        send_byte(SC_BRK, 1'b0);
        RESET = 1'b1;
        idle_cycles(2);
        check("s6_rst_held",  32'(KEYS_HELD), 32'(0));
        check("s6_rst_state", 32'(FSM_STATE), 32'(ST_IDLE));
        check("s6_rst_ovf",   32'(OVERFLOW), 32'(0));
        RESET = 1'b0;
        idle_cycles(1);
        exp_q.push_back({KEY_R, 1'b1});
        send_byte(SC_R, 1'b0);
        check("s6_make_r", 32'(KEYS_HELD), 32'(4'b0100));
        idle_cycles(3);

        check("q_empty",   32'(exp_q.size()), 32'(0));
        check("flap_count", 32'(flap_cnt), 32'(exp_flaps));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
